ifetch_unit: RTL

- Instruction-fetch stage of the single-cycle MIPS core; sits directly upstream of the register-file/decode stage.
- Holds the PC and drives a synchronous-read instruction memory.
- Presents the fetched Instruction and the link value (opcplus4) to decode.
- Selects the next PC from sequential, branch, jump and jr sources.
- Handles pipeline hold, UART program-load mode and a misaligned-target fault state.

---
 rtl/ifetch_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, synchronous BRAM addressing,
// program-load hold and sticky misaligned-target fault.
module ifetch_unit #(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instruction,
    output logic [31:0]       opcplus4,
    output logic [31:0]       pc,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              Zero,
    input  logic              stall,
    input  logic              upg_rst,
    output logic              fault,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {RUN, LOAD, FAULT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        advance;

    assign pc_plus4 = pc + 32'd4;
    assign opcplus4 = pc_plus4;

    always_comb begin
        target = pc_plus4;
        if (Jr)
            target = Read_data_1;
        else if (Jmp || Jal)
            target = {pc_plus4[31:28], Instruction[25:0], 2'b00};
        else if ((Branch && Zero) || (nBranch && !Zero))
            target = Addr_result;
    end

    // A misaligned target never reaches pc or memory; the fetch address holds instead.
    always_comb begin
        state_nxt = state;
        next_pc   = pc;
        advance   = 1'b0;
        case (state)
            RUN: begin
                if (upg_rst)
                    state_nxt = LOAD;
                else if (!stall) begin
                    if (target[1:0] != 2'b00)
                        state_nxt = FAULT;
                    else begin
                        next_pc = target;
                        advance = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (!upg_rst) begin
                    state_nxt = RUN;
                    next_pc   = RESET_PC;
                end
            end
            FAULT: begin
                if (upg_rst)
                    state_nxt = LOAD;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign imem_addr   = reset ? RESET_PC[ADDR_W+1:2] : next_pc[ADDR_W+1:2];
    assign Instruction = (state == RUN && !reset) ? imem_rdata : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pc      <= RESET_PC;
            fault   <= 1'b0;
            retired <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= next_pc;
            fault <= (state_nxt == FAULT);
            if (state == LOAD && !upg_rst)
                retired <= 32'd0;
            else if (advance)
                retired <= retired + 32'd1;
        end
    end

endmodule
